// File: rtl/rhs_conv_sequencer.sv
// Frame sequencer for the RHS front end: per sample tick, one CONVERT per channel plus
// pipeline-flush dummies through the SPI master, with single host commands arbitrated in between.
`timescale 1ns/1ps
module rhs_conv_sequencer #(
    parameter int unsigned N_CH       = 16,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter logic [31:0] DUMMY_CMD  = 32'hC0FF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_tick,
    input  logic        host_valid,
    input  logic [31:0] host_cmd,
    output logic        host_ready,
    output logic        host_rsp_valid,
    output logic [31:0] host_rsp,
    output logic        spi_start,
    output logic [31:0] spi_tx,
    input  logic        spi_done,
    input  logic [31:0] spi_rx,
    output logic        sample_valid,
    output logic [4:0]  sample_ch,
    output logic [15:0] sample_data,
    output logic        frame_done,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {FRAME, HOST} mode_t;

    localparam logic [5:0] FRAME_LAST = 6'(N_CH + PIPE_DEPTH - 1);
    localparam logic [5:0] HOST_LAST  = 6'(PIPE_DEPTH);
    localparam logic [5:0] PD         = 6'(PIPE_DEPTH);
    localparam logic [5:0] NCH        = 6'(N_CH);

    state_t      state, state_n;
    mode_t       mode, mode_n;
    logic [5:0]  idx, idx_n;
    logic [31:0] tx_n;
    logic        samp_v_n, fd_n, rsp_v_n, ovr_n, accept_host;
    logic [4:0]  samp_ch_n;
    logic [15:0] samp_d_n;
    logic [31:0] rsp_n;
    logic [5:0]  ch_full;
    logic        tick_req, last_txn;

    function automatic logic [31:0] frame_cmd(input logic [5:0] i);
        if (i < NCH) frame_cmd = {2'b00, 8'h00, 1'b0, i[4:0], 16'h0000};
        else         frame_cmd = DUMMY_CMD;
    endfunction

    assign tick_req   = sample_tick && enable;
    assign last_txn   = (mode == FRAME) ? (idx == FRAME_LAST) : (idx == HOST_LAST);
    assign ch_full    = idx - PD;
    assign busy       = (state != IDLE);
    assign spi_start  = (state == ISSUE);
    assign host_ready = accept_host && !rst;

    always_comb begin
        state_n     = state;
        mode_n      = mode;
        idx_n       = idx;
        tx_n        = spi_tx;
        samp_v_n    = 1'b0;
        samp_ch_n   = sample_ch;
        samp_d_n    = sample_data;
        fd_n        = 1'b0;
        rsp_v_n     = 1'b0;
        rsp_n       = host_rsp;
        accept_host = 1'b0;
        // ticks arriving while a sequence is in flight are dropped but remembered
        ovr_n       = overrun | (tick_req && (state != IDLE));
        case (state)
            IDLE: begin
                if (tick_req) begin
                    state_n = ISSUE;
                    mode_n  = FRAME;
                    idx_n   = '0;
                    tx_n    = frame_cmd(6'd0);
                end else if (host_valid) begin
                    accept_host = 1'b1;
                    state_n     = ISSUE;
                    mode_n      = HOST;
                    idx_n       = '0;
                    tx_n        = host_cmd;
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (spi_done) begin
                    // result of command idx-PIPE_DEPTH is arriving now
                    if (mode == FRAME && idx >= PD) begin
                        samp_v_n  = 1'b1;
                        samp_ch_n = ch_full[4:0];
                        samp_d_n  = spi_rx[15:0];
                    end
                    if (last_txn) begin
                        state_n = IDLE;
                        if (mode == FRAME) begin
                            fd_n = 1'b1;
                        end else begin
                            rsp_v_n = 1'b1;
                            rsp_n   = spi_rx;
                        end
                    end else begin
                        state_n = ISSUE;
                        idx_n   = idx + 6'd1;
                        tx_n    = (mode == FRAME) ? frame_cmd(idx + 6'd1) : DUMMY_CMD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mode           <= FRAME;
            idx            <= '0;
            spi_tx         <= '0;
            sample_valid   <= 1'b0;
            sample_ch      <= '0;
            sample_data    <= '0;
            frame_done     <= 1'b0;
            host_rsp_valid <= 1'b0;
            host_rsp       <= '0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_n;
            mode           <= mode_n;
            idx            <= idx_n;
            spi_tx         <= tx_n;
            sample_valid   <= samp_v_n;
            sample_ch      <= samp_ch_n;
            sample_data    <= samp_d_n;
            frame_done     <= fd_n;
            host_rsp_valid <= rsp_v_n;
            host_rsp       <= rsp_n;
            overrun        <= ovr_n;
        end
    end

endmodule

// File: tb/tb_rhs_conv_sequencer.sv
// Bench for rhs_conv_sequencer: behavioural SPI master, transaction-level model checked
// every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_rhs_conv_sequencer;

    localparam int N_CH = 16;
    localparam int PD   = 2;
    localparam int TOT  = N_CH + PD;
    localparam int LAT  = 29;
    localparam logic [31:0] DUMMY = 32'hC0FF_0000;
    localparam logic [31:0] XMASK = 32'h0000_A5A5;

    logic        clk = 1'b0;
    logic        rst, enable, sample_tick, host_valid;
    logic [31:0] host_cmd;
    logic        host_ready, host_rsp_valid;
    logic [31:0] host_rsp;
    logic        spi_start;
    logic [31:0] spi_tx;
    logic        spi_done = 1'b0;
    logic [31:0] spi_rx = '0;
    logic        sample_valid;
    logic [4:0]  sample_ch;
    logic [15:0] sample_data;
    logic        frame_done, busy, overrun;

    always #5 clk = ~clk;

    rhs_conv_sequencer #(.N_CH(N_CH), .PIPE_DEPTH(PD), .DUMMY_CMD(DUMMY)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
        .host_valid(host_valid), .host_cmd(host_cmd), .host_ready(host_ready),
        .host_rsp_valid(host_rsp_valid), .host_rsp(host_rsp),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_done(spi_done), .spi_rx(spi_rx),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .frame_done(frame_done), .busy(busy), .overrun(overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural SPI master: answers each start LAT+1 cycles later with rx = tx ^ A5A5.
    bit          pending = 1'b0;
    int          cnt = 0;
    int          n_done = 0;
    logic [31:0] tx_l;
    initial begin : master
        logic s_rst, s_start;
        logic [31:0] s_tx;
        forever begin
            @(negedge clk);
            s_rst = rst; s_start = spi_start; s_tx = spi_tx;
            @(posedge clk); #1;
            spi_done = 1'b0;
            if (s_rst === 1'b1) begin
                pending = 1'b0;
            end else if (pending) begin
                if (cnt == 0) begin
                    spi_done = 1'b1;
                    spi_rx   = tx_l ^ XMASK;
                    pending  = 1'b0;
                    n_done++;
                end else begin
                    cnt--;
                end
            end else if (s_start === 1'b1) begin
                pending = 1'b1;
                tx_l    = s_tx;
                cnt     = LAT;
            end
        end
    end

    // Transaction-level model: a sequence is a list of command words; results come back in order.
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0, m_frame = 1'b0, m_ovr = 1'b0;
    logic [31:0] seq [0:TOT-1];
    int          seq_len = 0, k_start = 0, k_done = 0;
    bit          start_now = 1'b0, samp_now = 1'b0, fd_now = 1'b0, rsp_now = 1'b0;
    logic [4:0]  samp_ch_e;
    logic [15:0] samp_d_e;
    logic [31:0] rsp_e;
    int          n_starts = 0, n_samples = 0, n_fd = 0, n_rsp = 0;
    logic [31:0] tx_log [$];

    always @(negedge clk) begin : cmp
        bit ready_exp, start_n, samp_n, fd_n, rsp_n;
        int k;
        logic [31:0] rx;
        if (chk_en) begin
            ready_exp = !rst && !m_busy && host_valid && !(sample_tick && enable);
            chk("busy", busy, m_busy);
            chk("overrun", overrun, m_ovr);
            chk("host_ready", host_ready, ready_exp);
            chk("spi_start", spi_start, start_now);
            if (spi_start) begin
                n_starts++;
                tx_log.push_back(spi_tx);
            end
            if (start_now) begin
                if (k_start < seq_len) chk("spi_tx", spi_tx, seq[k_start]);
                else chk("spi_tx_extra", 32'd1, 32'd0);
                k_start++;
            end
            chk("sample_valid", sample_valid, samp_now);
            if (sample_valid) n_samples++;
            if (sample_valid && samp_now) begin
                chk("sample_ch", sample_ch, samp_ch_e);
                chk("sample_data", sample_data, samp_d_e);
            end
            chk("frame_done", frame_done, fd_now);
            if (frame_done) n_fd++;
            chk("host_rsp_valid", host_rsp_valid, rsp_now);
            if (host_rsp_valid) n_rsp++;
            if (host_rsp_valid && rsp_now) chk("host_rsp", host_rsp, rsp_e);

            start_n = 0; samp_n = 0; fd_n = 0; rsp_n = 0;
            if (rst) begin
                m_busy = 0; m_ovr = 0; seq_len = 0; k_start = 0; k_done = 0;
            end else if (!m_busy) begin
                if (sample_tick && enable) begin
                    for (int i = 0; i < TOT; i++)
                        seq[i] = (i < N_CH) ? (32'(i) << 16) : DUMMY;
                    seq_len = TOT; m_frame = 1;
                    m_busy = 1; k_start = 0; k_done = 0; start_n = 1;
                end else if (host_valid) begin
                    seq[0] = host_cmd;
                    for (int i = 1; i <= PD; i++) seq[i] = DUMMY;
                    seq_len = PD + 1; m_frame = 0;
                    m_busy = 1; k_start = 0; k_done = 0; start_n = 1;
                end
            end else begin
                if (sample_tick && enable) m_ovr = 1;
                if (spi_done && k_start > k_done) begin
                    k = k_done;
                    k_done++;
                    rx = seq[k] ^ XMASK;
                    if (m_frame && k >= PD) begin
                        samp_n = 1;
                        samp_ch_e = 5'(k - PD);
                        samp_d_e = rx[15:0];
                    end
                    if (k == seq_len - 1) begin
                        m_busy = 0;
                        if (m_frame) fd_n = 1;
                        else begin rsp_n = 1; rsp_e = rx; end
                    end else begin
                        start_n = 1;
                    end
                end
            end
            start_now = start_n; samp_now = samp_n; fd_now = fd_n; rsp_now = rsp_n;
        end
    end

    task automatic pulse_tick();
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int b = 0;
        do begin @(negedge clk); b++; end while (!frame_done && b < 3000);
        chk({name, "_frame_done_seen"}, {31'b0, frame_done}, 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        int b = 0;
        do begin @(negedge clk); b++; end while (!host_rsp_valid && b < 500);
        chk({name, "_rsp_seen"}, {31'b0, host_rsp_valid}, 32'd1);
        chk({name, "_rsp_value"}, host_rsp, 32'hC0FF_A5A5);
    endtask

    task automatic wait_ready(input string name);
        int b = 0;
        do begin @(negedge clk); b++; end while (!host_ready && b < 100);
        chk({name, "_ready_seen"}, {31'b0, host_ready}, 32'd1);
    endtask

    // Waits for the negedge just before the master returns result number `target`.
    task automatic wait_pre_done(input string name, input int target);
        int b = 0;
        do begin @(negedge clk); b++; end
        while (!(pending && cnt == 0 && n_done == target - 1) && b < 3000);
        chk({name, "_pre_done_seen"}, 32'(b < 3000), 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int s0, nd0, tl0, sm0, r0, f0, b;
        rst = 1'b1; enable = 1'b1; sample_tick = 1'b0; host_valid = 1'b0; host_cmd = '0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_spi_tx", spi_tx, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_spi_start", {31'b0, spi_start}, 32'd0);
        chk("rst_sample_valid", {31'b0, sample_valid}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // single frame
        s0 = n_starts; sm0 = n_samples; f0 = n_fd; tl0 = tx_log.size();
        pulse_tick();
        wait_fd("frame1");
        @(posedge clk); #1;
        chk("frame1_starts", n_starts - s0, 32'd18);
        chk("frame1_samples", n_samples - sm0, 32'd16);
        chk("frame1_fd_count", n_fd - f0, 32'd1);
        chk("frame1_overrun", {31'b0, overrun}, 32'd0);
        chk("frame1_tx0", tx_log[tl0], 32'h0000_0000);
        chk("frame1_tx1", tx_log[tl0 + 1], 32'h0001_0000);
        chk("frame1_tx15", tx_log[tl0 + 15], 32'h000F_0000);
        chk("frame1_tx16", tx_log[tl0 + 16], 32'hC0FF_0000);
        chk("frame1_tx17", tx_log[tl0 + 17], 32'hC0FF_0000);

        // tick mid-frame: overrun, tick dropped
        s0 = n_starts; nd0 = n_done;
        pulse_tick();
        b = 0;
        do begin @(negedge clk); b++; end while (n_done < nd0 + 5 && b < 3000);
        pulse_tick();
        @(posedge clk); #1;
        chk("mid_overrun_set", {31'b0, overrun}, 32'd1);
        wait_fd("frame2");
        repeat (60) @(posedge clk);
        #1;
        chk("frame2_starts", n_starts - s0, 32'd18);
        chk("frame2_idle", {31'b0, busy}, 32'd0);
        chk("overrun_sticky", {31'b0, overrun}, 32'd1);

        // host command from IDLE
        sm0 = n_samples; r0 = n_rsp; tl0 = tx_log.size();
        @(posedge clk); #1 host_cmd = 32'h8A12_3456; host_valid = 1'b1;
        wait_ready("host1");
        @(posedge clk); #1 host_valid = 1'b0;
        wait_rsp("host1");
        @(posedge clk); #1;
        chk("host1_no_samples", n_samples - sm0, 32'd0);
        chk("host1_rsp_count", n_rsp - r0, 32'd1);
        chk("host1_tx0", tx_log[tl0], 32'h8A12_3456);
        chk("host1_tx1", tx_log[tl0 + 1], 32'hC0FF_0000);
        chk("host1_tx2", tx_log[tl0 + 2], 32'hC0FF_0000);

        // simultaneous tick and host request: frame first, host right after frame_done
        @(posedge clk); #1 sample_tick = 1'b1; host_valid = 1'b1; host_cmd = 32'h1234_5678;
        @(posedge clk); #1 sample_tick = 1'b0;
        wait_fd("frame3");
        chk("host2_ready_at_fd", {31'b0, host_ready}, 32'd1);
        @(posedge clk); #1 host_valid = 1'b0;
        wait_rsp("host2");

        // reset mid-frame
        s0 = n_starts; nd0 = n_done; f0 = n_fd;
        pulse_tick();
        b = 0;
        do begin @(negedge clk); b++; end while (!(spi_done && n_done == nd0 + 7) && b < 3000);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_spi_start", {31'b0, spi_start}, 32'd0);
        chk("rstmid_spi_tx", spi_tx, 32'h0);
        chk("rstmid_overrun", {31'b0, overrun}, 32'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("rstmid_no_fd", n_fd - f0, 32'd0);
        chk("rstmid_starts", n_starts - s0, 32'd8);
        s0 = n_starts; tl0 = tx_log.size();
        pulse_tick();
        wait_fd("frame4");
        @(posedge clk); #1;
        chk("frame4_starts", n_starts - s0, 32'd18);
        chk("frame4_tx0", tx_log[tl0], 32'h0000_0000);

        // enable low: ticks ignored
        enable = 1'b0; s0 = n_starts;
        pulse_tick();
        repeat (3) @(posedge clk);
        pulse_tick();
        repeat (10) @(posedge clk);
        #1;
        chk("disabled_no_start", n_starts - s0, 32'd0);
        chk("disabled_no_overrun", {31'b0, overrun}, 32'd0);
        enable = 1'b1;

        // tick one cycle after last done starts a new frame
        s0 = n_starts; nd0 = n_done;
        pulse_tick();
        wait_pre_done("frameA", nd0 + 18);
        @(posedge clk); #1;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(negedge clk);
        chk("frameB_started", {31'b0, busy}, 32'd1);
        chk("frameB_no_overrun", {31'b0, overrun}, 32'd0);

        // tick exactly at last done of frame B: overrun, no new frame
        wait_pre_done("frameB", nd0 + 36);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(negedge clk);
        chk("edge_overrun", {31'b0, overrun}, 32'd1);
        chk("edge_idle", {31'b0, busy}, 32'd0);
        repeat (60) @(posedge clk);
        #1;
        chk("edge_starts", n_starts - s0, 32'd36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
